// File: rtl/xm_pipe_reg_pkg.sv
// xm_pipe_reg_pkg: shared definitions for the Execute->Memory pipeline register.
//   Provides default widths, the ENABLE/DISABLE flag enum, the forwarding-select
//   type and the {addr, val, ctrl} entry layout carried through the stage.
package xm_pipe_reg_pkg;

    localparam int XM_DW   = 32;
    localparam int XM_CW   = 8;
    localparam int XM_NFWD = 2;
    localparam int XM_SCW  = 16;

    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } signal_e;

    typedef logic [XM_NFWD-1:0] fwd_sel_t;

    // Field order matches the packed payload {addr, val, ctrl} used by the top.
    typedef struct packed {
        logic [XM_DW-1:0] addr;
        logic [XM_DW-1:0] val;
        logic [XM_CW-1:0] ctrl;
    } xm_entry_t;

endpackage

// File: rtl/xm_pipe_reg_skid.sv
// pipe_skid: generic two-entry valid/ready skid buffer.
//   clk, rst (async, active-low), flush (drop all entries)
//   in_valid/in_ready/in_data   : upstream handshake
//   out_valid/out_ready/out_data: downstream handshake, driven from main entry
//   occ                          : entries held (0..2)
module pipe_skid
    import xm_pipe_reg_pkg::*;
#(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occ
);

    signal_e        main_v, skid_v;
    logic [W-1:0]   main_d, skid_d;
    logic           acc, cons;

    // Ready depends only on the skid flag, so it never forms a comb path from out_ready.
    assign in_ready  = (skid_v == DISABLE);
    assign out_valid = (main_v == ENABLE);
    assign out_data  = main_d;
    assign acc       = in_valid & in_ready & !flush;
    assign cons      = out_valid & out_ready;
    assign occ       = 2'(main_v) + 2'(skid_v);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v <= DISABLE;
            skid_v <= DISABLE;
            main_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            main_v <= DISABLE;
            skid_v <= DISABLE;
        end else if (cons) begin
            // Skid refills main on consume; acc cannot coincide since in_ready=0 then.
            if (skid_v == ENABLE) begin
                main_d <= skid_d;
                skid_v <= DISABLE;
            end else if (acc) begin
                main_d <= in_data;
            end
            main_v <= (skid_v == ENABLE || acc) ? ENABLE : DISABLE;
        end else if (acc) begin
            if (main_v == ENABLE) begin
                skid_d <= in_data;
                skid_v <= ENABLE;
            end else begin
                main_d <= in_data;
                main_v <= ENABLE;
            end
        end
    end

endmodule

// File: rtl/xm_pipe_reg.sv
// xm_pipe_reg: Execute->Memory pipeline register with skid buffer, store-data
//   forwarding, bubble masking and a saturating stall-cycle counter.
//   clk, rst (async, active-low), flush
//   x_valid/x_ready, x_alu, x_rt, x_ctrl, fwd_sel, fwd_data : Execute side
//   m_valid/m_ready, m_addr, m_val, m_ctrl                  : Memory side
//   occ (entries held), stall_cnt (cycles m_valid & !m_ready)
module xm_pipe_reg
    import xm_pipe_reg_pkg::*;
#(
    parameter int DW   = XM_DW,
    parameter int CW   = XM_CW,
    parameter int NFWD = XM_NFWD,
    parameter int SCW  = XM_SCW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [DW-1:0]    x_alu,
    input  logic [DW-1:0]    x_rt,
    input  logic [CW-1:0]    x_ctrl,
    input  logic [NFWD-1:0]  fwd_sel,
    input  logic [NFWD*DW-1:0] fwd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_addr,
    output logic [DW-1:0]    m_val,
    output logic [CW-1:0]    m_ctrl,
    output logic [1:0]       occ,
    output logic [SCW-1:0]   stall_cnt
);

    localparam int PW = DW + DW + CW;

    logic [DW-1:0] st_val;
    logic [CW-1:0] ctrl_q;
    logic [PW-1:0] out_d;

    // Walk from the highest index down so the lowest enabled source wins.
    always_comb begin
        st_val = x_rt;
        for (int i = NFWD - 1; i >= 0; i--)
            if (fwd_sel[i]) st_val = fwd_data[i*DW +: DW];
    end

    pipe_skid #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (x_valid),
        .in_ready  (x_ready),
        .in_data   ({x_alu, st_val, x_ctrl}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (out_d),
        .occ       (occ)
    );

    assign {m_addr, m_val, ctrl_q} = out_d;
    assign m_ctrl = m_valid ? ctrl_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (m_valid && !m_ready && stall_cnt != {SCW{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_xm_pipe_reg.sv
// tb_xm_pipe_reg: directed self-checking bench for xm_pipe_reg (SCW=4).
module tb_xm_pipe_reg;

    localparam int DW = 32, CW = 8, NFWD = 2, SCW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0, x_valid = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] x_alu = '0, x_rt = '0;
    logic [CW-1:0] x_ctrl = '0;
    logic [NFWD-1:0] fwd_sel = '0;
    logic [NFWD*DW-1:0] fwd_data = '0;
    logic x_ready, m_valid;
    logic [DW-1:0] m_addr, m_val;
    logic [CW-1:0] m_ctrl;
    logic [1:0] occ;
    logic [SCW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xm_pipe_reg #(.DW(DW), .CW(CW), .NFWD(NFWD), .SCW(SCW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .x_valid(x_valid), .x_ready(x_ready), .x_alu(x_alu), .x_rt(x_rt),
        .x_ctrl(x_ctrl), .fwd_sel(fwd_sel), .fwd_data(fwd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_val(m_val),
        .m_ctrl(m_ctrl), .occ(occ), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_occ", 32'(occ), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_ctrl", 32'(m_ctrl), 0);
        chk("rst_x_ready", 32'(x_ready), 1);
        tick();
        tick();
        rst = 1'b1;

        // streaming
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x_valid = 1'b1;
            x_alu = 32'h10 + 32'(4 * k);
            x_ctrl = 8'(k + 1);
            tick();
            chk("str_addr", m_addr, 32'h10 + 32'(4 * k));
            chk("str_ctrl", 32'(m_ctrl), 32'(k + 1));
            chk("str_occ", 32'(occ), 1);
        end
        x_valid = 1'b0;
        tick();
        chk("str_drain_valid", 32'(m_valid), 0);
        chk("str_drain_ctrl", 32'(m_ctrl), 0);
        chk("str_stall", 32'(stall_cnt), 0);

        // back-pressure
        m_ready = 1'b0;
        x_valid = 1'b1; x_alu = 32'h100; x_ctrl = 8'hA1;
        tick();
        chk("bp_a_addr", m_addr, 32'h100);
        x_alu = 32'h104; x_ctrl = 8'hB2;
        tick();
        chk("bp_occ2", 32'(occ), 2);
        chk("bp_x_ready", 32'(x_ready), 0);
        chk("bp_hold_addr", m_addr, 32'h100);
        x_valid = 1'b0;
        tick();
        chk("bp_stall2", 32'(stall_cnt), 2);
        chk("bp_hold_ctrl", 32'(m_ctrl), 32'hA1);
        m_ready = 1'b1;
        tick();
        chk("bp_b_addr", m_addr, 32'h104);
        chk("bp_b_ctrl", 32'(m_ctrl), 32'hB2);
        chk("bp_occ1", 32'(occ), 1);
        chk("bp_x_ready_back", 32'(x_ready), 1);
        tick();
        chk("bp_empty", 32'(m_valid), 0);
        chk("bp_stall_final", 32'(stall_cnt), 2);

        // forwarding
        x_valid = 1'b1; x_alu = 32'h20; x_rt = 32'hAAAA;
        fwd_data = {32'h2222, 32'h1111};
        fwd_sel = 2'b11;
        tick();
        chk("fwd_11", m_val, 32'h1111);
        fwd_sel = 2'b10;
        tick();
        chk("fwd_10", m_val, 32'h2222);
        fwd_sel = 2'b00;
        tick();
        chk("fwd_00", m_val, 32'hAAAA);
        x_valid = 1'b0; m_ready = 1'b0; fwd_sel = 2'b01;
        tick();
        chk("fwd_frozen", m_val, 32'hAAAA);
        chk("fwd_stall", 32'(stall_cnt), 3);

        // flush with both entries held and Execute presenting
        x_valid = 1'b1; x_alu = 32'h200; x_ctrl = 8'h33;
        tick();
        chk("fl_occ2", 32'(occ), 2);
        x_alu = 32'h300; flush = 1'b1;
        tick();
        chk("fl_m_valid", 32'(m_valid), 0);
        chk("fl_m_ctrl", 32'(m_ctrl), 0);
        chk("fl_occ", 32'(occ), 0);
        chk("fl_x_ready", 32'(x_ready), 1);
        chk("fl_stall_kept", 32'(stall_cnt), 5);
        // flush beats a genuine accept
        flush = 1'b0; m_ready = 1'b1; x_alu = 32'h400;
        tick();
        chk("fl2_pre", m_addr, 32'h400);
        flush = 1'b1; x_alu = 32'h404;
        tick();
        chk("fl2_occ", 32'(occ), 0);
        chk("fl2_valid", 32'(m_valid), 0);
        flush = 1'b0;

        // async reset while full
        m_ready = 1'b0; x_alu = 32'h500;
        tick();
        x_alu = 32'h504;
        tick();
        chk("ar_occ2", 32'(occ), 2);
        chk("ar_stall6", 32'(stall_cnt), 6);
        x_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("ar_m_valid", 32'(m_valid), 0);
        chk("ar_occ", 32'(occ), 0);
        chk("ar_stall", 32'(stall_cnt), 0);
        chk("ar_m_addr", m_addr, 0);
        chk("ar_x_ready", 32'(x_ready), 1);
        tick();
        rst = 1'b1;
        x_valid = 1'b1; x_alu = 32'h600; x_ctrl = 8'h5C; m_ready = 1'b1;
        tick();
        chk("ar_first_addr", m_addr, 32'h600);
        chk("ar_first_ctrl", 32'(m_ctrl), 32'h5C);

        // counter saturation
        x_valid = 1'b0; m_ready = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        chk("sat_15", 32'(stall_cnt), 15);
        for (int k = 0; k < 5; k++) tick();
        chk("sat_20", 32'(stall_cnt), 15);
        chk("sat_hold_addr", m_addr, 32'h600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
